// File: rtl/ibex_pkg.sv
// Shared types for the inter-core message port.
package ibex_pkg;

  localparam int unsigned MsgLenW = 2;

  typedef struct packed {
    logic [4:0]         addr;
    logic [MsgLenW-1:0] len;
    logic [31:0]        data;
    logic [31:0]        msg1;
    logic [31:0]        msg2;
    logic [31:0]        msg3;
  } msg_pkt_t;

  // Zero every message word whose index exceeds the packet length.
  function automatic msg_pkt_t msg_mask(msg_pkt_t p);
    msg_pkt_t m;
    m = p;
    if (p.len < MsgLenW'(1)) m.msg1 = '0;
    if (p.len < MsgLenW'(2)) m.msg2 = '0;
    if (p.len < MsgLenW'(3)) m.msg3 = '0;
    return m;
  endfunction

endpackage

// File: rtl/ibex_msg_fifo.sv
// First-word-fall-through FIFO of message packets, wrap-bit pointers.
module ibex_msg_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  msg_pkt_t        wdata_i,
  output msg_pkt_t        rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned AddrW = CntW - 1;

  logic [CntW-1:0] r_wptr;
  logic [CntW-1:0] r_rptr;
  msg_pkt_t        r_mem [Depth];

  logic            w_do_pop;
  logic            w_do_push;

  assign count_o   = r_wptr - r_rptr;
  assign empty_o   = (count_o == '0);
  assign full_o    = (count_o == CntW'(Depth));
  // A pop frees the slot the same-edge push needs, so push at full is fine then.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointer registers; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + CntW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + CntW'(1);
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr[AddrW-1:0]] <= wdata_i;
  end

  // Head is gated to zero while empty so stale storage never leaks out.
  assign rdata_o = empty_o ? '0 : r_mem[r_rptr[AddrW-1:0]];

endmodule

// File: rtl/ibex_msg_mailbox.sv
// Receive-side message mailbox: masks and buffers producer pulses,
// hands them to the consumer over valid/ready, counts drops.
module ibex_msg_mailbox
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               prod_valid_i,
  input  logic [4:0]         prod_addr_i,
  input  logic [MsgLenW-1:0] prod_len_i,
  input  logic [31:0]        prod_data_i,
  input  logic [31:0]        prod_msg1_i,
  input  logic [31:0]        prod_msg2_i,
  input  logic [31:0]        prod_msg3_i,
  output logic               cons_valid_o,
  input  logic               cons_ready_i,
  output logic [4:0]         cons_addr_o,
  output logic [MsgLenW-1:0] cons_len_o,
  output logic [31:0]        cons_data_o,
  output logic [31:0]        cons_msg1_o,
  output logic [31:0]        cons_msg2_o,
  output logic [31:0]        cons_msg3_o,
  output logic [CntW-1:0]    count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o,
  input  logic               clear_i
);

  msg_pkt_t w_wdata;
  msg_pkt_t w_head;
  logic     w_pop;
  logic     w_drop;

  logic       r_overflow;
  logic [7:0] r_drop_cnt;

  // Build the packet and apply length masking before it is stored.
  always_comb begin
    w_wdata      = '0;
    w_wdata.addr = prod_addr_i;
    w_wdata.len  = prod_len_i;
    w_wdata.data = prod_data_i;
    w_wdata.msg1 = prod_msg1_i;
    w_wdata.msg2 = prod_msg2_i;
    w_wdata.msg3 = prod_msg3_i;
    w_wdata      = msg_mask(w_wdata);
  end

  ibex_msg_fifo #(
    .Depth (Depth),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (prod_valid_i),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_head),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign cons_valid_o = !empty_o;
  assign w_pop        = cons_valid_o && cons_ready_i;
  assign w_drop       = prod_valid_i && full_o && !w_pop;

  assign cons_addr_o  = w_head.addr;
  assign cons_len_o   = w_head.len;
  assign cons_data_o  = w_head.data;
  assign cons_msg1_o  = w_head.msg1;
  assign cons_msg2_o  = w_head.msg2;
  assign cons_msg3_o  = w_head.msg3;

  // Sticky overflow and saturating drop count; a same-edge drop beats clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_i)              r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_ibex_msg_mailbox.sv
// Directed, table-driven bench for ibex_msg_mailbox.
module tb_ibex_msg_mailbox;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        prod_valid_i;
  logic [4:0]  prod_addr_i;
  logic [1:0]  prod_len_i;
  logic [31:0] prod_data_i, prod_msg1_i, prod_msg2_i, prod_msg3_i;
  logic        cons_valid_o;
  logic        cons_ready_i;
  logic [4:0]  cons_addr_o;
  logic [1:0]  cons_len_o;
  logic [31:0] cons_data_o, cons_msg1_o, cons_msg2_o, cons_msg3_o;
  logic [2:0]  count_o;
  logic        full_o, empty_o, overflow_o;
  logic [7:0]  drop_cnt_o;
  logic        clear_i;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ibex_msg_mailbox #(.Depth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_valid_i(prod_valid_i), .prod_addr_i(prod_addr_i), .prod_len_i(prod_len_i),
    .prod_data_i(prod_data_i), .prod_msg1_i(prod_msg1_i), .prod_msg2_i(prod_msg2_i),
    .prod_msg3_i(prod_msg3_i),
    .cons_valid_o(cons_valid_o), .cons_ready_i(cons_ready_i),
    .cons_addr_o(cons_addr_o), .cons_len_o(cons_len_o), .cons_data_o(cons_data_o),
    .cons_msg1_o(cons_msg1_o), .cons_msg2_o(cons_msg2_o), .cons_msg3_o(cons_msg3_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        pv;
    logic [4:0]  addr;
    logic [1:0]  len;
    logic [31:0] data, m1, m2, m3;
    logic        rdy, clr;
    logic        ev;
    logic [2:0]  ecnt;
    logic [4:0]  eaddr;
    logic [1:0]  elen;
    logic [31:0] edata, e1, e2, e3;
    logic        eovf;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(
    logic pv, logic [4:0] addr, logic [1:0] len, logic [31:0] data,
    logic [31:0] m1, logic [31:0] m2, logic [31:0] m3, logic rdy, logic clr,
    logic ev, logic [2:0] ecnt, logic [4:0] eaddr, logic [1:0] elen, logic [31:0] edata,
    logic [31:0] e1, logic [31:0] e2, logic [31:0] e3, logic eovf, logic [7:0] edrop);
    vec_t v;
    v.pv = pv; v.addr = addr; v.len = len; v.data = data;
    v.m1 = m1; v.m2 = m2; v.m3 = m3; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ecnt = ecnt; v.eaddr = eaddr; v.elen = elen; v.edata = edata;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eovf = eovf; v.edrop = edrop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] addr, input logic [1:0] len,
                       input logic [31:0] data, input logic [31:0] m1, input logic [31:0] m2,
                       input logic [31:0] m3, input logic rdy, input logic clr);
    prod_valid_i = pv; prod_addr_i = addr; prod_len_i = len; prod_data_i = data;
    prod_msg1_i = m1; prod_msg2_i = m2; prod_msg3_i = m3;
    cons_ready_i = rdy; clear_i = clr;
  endtask

  // Advance one edge and land 1 time unit after it for sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [4:0] a, input logic [1:0] l,
                          input logic [31:0] d, input logic [31:0] m1,
                          input logic [31:0] m2, input logic [31:0] m3);
    chk({tag, ".addr"}, 32'(cons_addr_o), 32'(a));
    chk({tag, ".len"},  32'(cons_len_o),  32'(l));
    chk({tag, ".data"}, cons_data_o, d);
    chk({tag, ".msg1"}, cons_msg1_o, m1);
    chk({tag, ".msg2"}, cons_msg2_o, m2);
    chk({tag, ".msg3"}, cons_msg3_o, m3);
  endtask

  initial begin
    // in: pv addr len data m1 m2 m3 rdy clr | exp: v cnt addr len data m1 m2 m3 ovf drop
    // single push into empty with ready high: no pop that edge, then popped
    vecs.push_back(mkv(1, 5'h03, 2, 32'hA5A5_0001, 1, 2, 3, 1, 0,  1, 1, 5'h03, 2, 32'hA5A5_0001, 1, 2, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Depth+2 pushes with backpressure; head stays on the first message
    vecs.push_back(mkv(1, 5'd10, 3, 32'd100, 11, 12, 13, 0, 0,      1, 1, 5'd10, 3, 32'd100, 11, 12, 13, 0, 0));
    vecs.push_back(mkv(1, 5'd11, 1, 32'd101, 21, 22, 23, 0, 0,      1, 2, 5'd10, 3, 32'd100, 11, 12, 13, 0, 0));
    vecs.push_back(mkv(1, 5'd12, 0, 32'd102, 31, 32, 33, 0, 0,      1, 3, 5'd10, 3, 32'd100, 11, 12, 13, 0, 0));
    vecs.push_back(mkv(1, 5'd13, 2, 32'd103, 41, 42, 43, 0, 0,      1, 4, 5'd10, 3, 32'd100, 11, 12, 13, 0, 0));
    vecs.push_back(mkv(1, 5'd14, 3, 32'd104, 51, 52, 53, 0, 0,      1, 4, 5'd10, 3, 32'd100, 11, 12, 13, 1, 1));
    vecs.push_back(mkv(1, 5'd15, 3, 32'd105, 55, 56, 57, 0, 0,      1, 4, 5'd10, 3, 32'd100, 11, 12, 13, 1, 2));
    // push and pop at full: no drop, count stays 4
    vecs.push_back(mkv(1, 5'd16, 3, 32'd106, 61, 62, 63, 1, 0,      1, 4, 5'd11, 1, 32'd101, 21, 0, 0, 1, 2));
    // drain in order, masked words read back as zero
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,                   1, 3, 5'd12, 0, 32'd102, 0, 0, 0, 1, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,                   1, 2, 5'd13, 2, 32'd103, 41, 42, 0, 1, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,                   1, 1, 5'd16, 3, 32'd106, 61, 62, 63, 1, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    chk("reset.valid", 32'(cons_valid_o), 0);
    chk("reset.count", 32'(count_o), 0);
    chk("reset.empty", 32'(empty_o), 1);
    chk("reset.full",  32'(full_o), 0);
    chk("reset.ovf",   32'(overflow_o), 0);
    chk("reset.drop",  32'(drop_cnt_o), 0);
    chk("reset.data",  cons_data_o, 0);
    step();
    step();
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      string t;
      v = vecs[i];
      t = $sformatf("v%0d", i);
      drive(v.pv, v.addr, v.len, v.data, v.m1, v.m2, v.m3, v.rdy, v.clr);
      step();
      chk({t, ".valid"}, 32'(cons_valid_o), 32'(v.ev));
      chk({t, ".count"}, 32'(count_o), 32'(v.ecnt));
      chk({t, ".full"},  32'(full_o),  32'(v.ecnt == 3'd4));
      chk({t, ".empty"}, 32'(empty_o), 32'(v.ecnt == 3'd0));
      chk({t, ".ovf"},   32'(overflow_o), 32'(v.eovf));
      chk({t, ".drop"},  32'(drop_cnt_o), 32'(v.edrop));
      chk_head(t, v.eaddr, v.elen, v.edata, v.e1, v.e2, v.e3);
    end

    // Reset mid-operation: three queued, asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 3, 32'(200 + i), 1, 2, 3, 0, 0);
      step();
    end
    chk("rstmid.pre_count", 32'(count_o), 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid.valid", 32'(cons_valid_o), 0);
    chk("rstmid.count", 32'(count_o), 0);
    chk("rstmid.empty", 32'(empty_o), 1);
    chk("rstmid.data",  cons_data_o, 0);
    rst_i = 1'b0;
    drive(1, 5'h1F, 1, 32'hDEAD_BEEF, 7, 8, 9, 0, 0);
    step();
    chk("rstmid.post_valid", 32'(cons_valid_o), 1);
    chk("rstmid.post_count", 32'(count_o), 1);
    chk_head("rstmid.post", 5'h1F, 1, 32'hDEAD_BEEF, 7, 0, 0);

    // Clear vs. drop: fill, then 300 drops saturate the counter at 255
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i), 0, 32'(i), 0, 0, 0, 0, 0);
      step();
    end
    chk("sat.full", 32'(full_o), 1);
    for (int i = 0; i < 300; i++) begin
      drive(1, 5'h02, 0, 32'h55, 0, 0, 0, 0, 0);
      step();
    end
    chk("sat.drop",  32'(drop_cnt_o), 255);
    chk("sat.ovf",   32'(overflow_o), 1);
    chk("sat.count", 32'(count_o), 4);
    chk_head("sat", 5'h1F, 1, 32'hDEAD_BEEF, 7, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("clear.drop", 32'(drop_cnt_o), 0);
    chk("clear.ovf",  32'(overflow_o), 0);
    drive(1, 5'h02, 0, 32'h55, 0, 0, 0, 0, 1);
    step();
    chk("clrdrop.drop", 32'(drop_cnt_o), 1);
    chk("clrdrop.ovf",  32'(overflow_o), 1);
    chk("clrdrop.count", 32'(count_o), 4);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
